// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: register-file sizing, free-list pointer
// layout and the pointer arithmetic used by the free list.
package ooo_pkg;
    localparam int NUM_PREGS = 128;
    localparam int NUM_AREGS = 32;
    localparam int NUM_CKPT  = 4;
    localparam int DEPTH     = NUM_PREGS - NUM_AREGS;
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int CKPT_W    = $clog2(NUM_CKPT);
    localparam int CNT_W     = $clog2(DEPTH + 1);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [CKPT_W-1:0] ckpt_id_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef struct packed {
        logic wrap;
        idx_t idx;
    } ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p.idx == idx_t'(DEPTH - 1)) begin
            r.idx  = '0;
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = p.idx + idx_t'(1);
            r.wrap = p.wrap;
        end
        return r;
    endfunction

    // Occupancy between head and tail; differing wrap bits mean tail has lapped.
    function automatic cnt_t ptr_dist(input ptr_t tail, input ptr_t head);
        if (tail.wrap == head.wrap) begin
            return cnt_t'(tail.idx) - cnt_t'(head.idx);
        end else begin
            return cnt_t'(DEPTH) - cnt_t'(head.idx) + cnt_t'(tail.idx);
        end
    endfunction

    function automatic logic in_range(input ptr_t head, input ptr_t tail, input idx_t i);
        if (head.wrap == tail.wrap) begin
            return (i >= head.idx) && (i < tail.idx);
        end else begin
            return (i >= head.idx) || (i < tail.idx);
        end
    endfunction
endpackage

// File: rtl/free_list_if.sv
// Rename/commit/branch-recovery port bundle of the physical register free list.
interface free_list_if;
    import ooo_pkg::*;

    logic     alloc_req;
    logic     alloc_valid;
    preg_t    alloc_preg;
    logic     free_valid;
    preg_t    free_preg;
    logic     ckpt_save;
    ckpt_id_t ckpt_id;
    logic     recover;
    ckpt_id_t recover_id;
    cnt_t     free_count;
    logic     empty;
    logic     dbl_free_err;

    modport master (
        output alloc_req, free_valid, free_preg, ckpt_save, ckpt_id, recover, recover_id,
        input  alloc_valid, alloc_preg, free_count, empty, dbl_free_err
    );

    modport slave (
        input  alloc_req, free_valid, free_preg, ckpt_save, ckpt_id, recover, recover_id,
        output alloc_valid, alloc_preg, free_count, empty, dbl_free_err
    );
endinterface

// File: rtl/free_list_ckpt_table.sv
// Branch checkpoint storage for the free-list head pointer: one write port,
// one asynchronous read port.
module free_list_ckpt_table
    import ooo_pkg::*;
#(
    parameter int N = NUM_CKPT
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     we,
    input  ckpt_id_t waddr,
    input  ptr_t     wdata,
    input  ckpt_id_t raddr,
    output ptr_t     rdata
);
    ptr_t slot_q [N];
    ptr_t slot_d [N];

    // Next-state of the checkpoint slots
    always_comb begin
        slot_d = slot_q;
        if (we) begin
            slot_d[waddr] = wdata;
        end else begin
            slot_d = slot_q;
        end
    end

    // Slot registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    assign rdata = slot_q[raddr];
endmodule

// File: rtl/free_list.sv
// Physical register free list: circular queue with checkpointed head pointer.
// Optional double-free detection is built when FREE_LIST_DBLFREE_CHECK_EN is defined.
module free_list
    import ooo_pkg::*;
#(
    parameter int NUM_PREGS = ooo_pkg::NUM_PREGS,
    parameter int NUM_AREGS = ooo_pkg::NUM_AREGS,
    parameter int NUM_CKPT  = ooo_pkg::NUM_CKPT
) (
    input  logic          clk,
    input  logic          reset,
    free_list_if.slave    fl
);
    localparam int DEPTH_L = NUM_PREGS - NUM_AREGS;

    preg_t queue_q [DEPTH_L];
    preg_t queue_d [DEPTH_L];
    ptr_t  head_q, head_d, tail_q, tail_d, head_alloc_s, ckpt_head_s;
    cnt_t  free_count_q, free_count_d;
    logic  empty_q, empty_d;
    logic  alloc_ok_s, free_ok_s, dup_s;

    assign fl.alloc_valid = !empty_q && !fl.recover;
    assign fl.alloc_preg  = queue_q[head_q.idx];
    assign fl.free_count  = free_count_q;
    assign fl.empty       = empty_q;

    assign alloc_ok_s   = fl.alloc_req && fl.alloc_valid;
    assign free_ok_s    = fl.free_valid && (fl.free_preg != '0)
                          && (free_count_q != cnt_t'(DEPTH_L)) && !dup_s;
    assign head_alloc_s = alloc_ok_s ? ptr_inc(head_q) : head_q;

    free_list_ckpt_table #(.N(NUM_CKPT)) u_ckpt (
        .clk   (clk),
        .reset (reset),
        .we    (fl.ckpt_save && !fl.recover),
        .waddr (fl.ckpt_id),
        .wdata (head_alloc_s),
        .raddr (fl.recover_id),
        .rdata (ckpt_head_s)
    );

    // Queue, pointer and occupancy next-state; recovery overrides the head only
    always_comb begin
        queue_d = queue_q;
        tail_d  = tail_q;
        if (free_ok_s) begin
            queue_d[tail_q.idx] = fl.free_preg;
            tail_d              = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        if (fl.recover) begin
            head_d       = ckpt_head_s;
            free_count_d = ptr_dist(tail_d, ckpt_head_s);
        end else begin
            head_d       = head_alloc_s;
            free_count_d = free_count_q + cnt_t'(free_ok_s) - cnt_t'(alloc_ok_s);
        end
        empty_d = (free_count_d == '0);
    end

    // Queue state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_L; i++) begin
                queue_q[i] <= preg_t'(NUM_AREGS + i);
            end
            head_q       <= '{wrap: 1'b0, idx: '0};
            tail_q       <= '{wrap: 1'b1, idx: '0};
            free_count_q <= cnt_t'(DEPTH_L);
            empty_q      <= 1'b0;
        end else begin
            queue_q      <= queue_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            free_count_q <= free_count_d;
            empty_q      <= empty_d;
        end
    end

`ifdef FREE_LIST_DBLFREE_CHECK_EN
    logic [NUM_PREGS-1:0] in_q_q, in_q_d;
    logic                 dbl_err_q, dbl_err_d;

    assign dup_s           = in_q_q[fl.free_preg];
    assign fl.dbl_free_err = dbl_err_q;

    // In-queue bitmap; on recovery it is rebuilt from the restored queue window
    always_comb begin
        in_q_d = in_q_q;
        if (fl.recover) begin
            in_q_d = '0;
            for (int i = 0; i < DEPTH_L; i++) begin
                in_q_d[queue_d[i]] = in_q_d[queue_d[i]] | in_range(head_d, tail_d, idx_t'(i));
            end
        end else begin
            if (alloc_ok_s) begin
                in_q_d[fl.alloc_preg] = 1'b0;
            end else begin
                in_q_d = in_q_q;
            end
            if (free_ok_s) begin
                in_q_d[fl.free_preg] = 1'b1;
            end else begin
                in_q_d = in_q_d;
            end
        end
        dbl_err_d = dbl_err_q | (fl.free_valid && (fl.free_preg != '0) && dup_s);
    end

    // Bitmap and sticky error registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                in_q_q[i] <= (i >= NUM_AREGS) ? 1'b1 : 1'b0;
            end
            dbl_err_q <= 1'b0;
        end else begin
            in_q_q    <= in_q_d;
            dbl_err_q <= dbl_err_d;
        end
    end
`else
    assign dup_s           = 1'b0;
    assign fl.dbl_free_err = 1'b0;
`endif
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 128, meaning physical register count.
REQ-002 SHALL have parameter NUM_AREGS, default 32, meaning architectural register count; initial mappings use p0..p31.
REQ-003 SHALL have parameter NUM_CKPT, default 4, meaning branch checkpoint slots.
REQ-004 SHALL have port clk  input  1  clock; reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port alloc_req  input  1  rename requests one physical register this cycle.
REQ-006 SHALL have port alloc_valid  output  1  a free register is offered at alloc_preg.
REQ-007 SHALL have port alloc_preg  output  $clog2(NUM_PREGS)  register at queue head.
REQ-008 SHALL have port free_valid  input  1  commit releases free_preg (old destination mapping).
REQ-009 SHALL have port free_preg  input  $clog2(NUM_PREGS)  register being released.
REQ-010 SHALL have port ckpt_save  input  1  snapshot head pointer into slot ckpt_id.
REQ-011 SHALL have port ckpt_id  input  $clog2(NUM_CKPT)  checkpoint slot written by ckpt_save.
REQ-012 SHALL have port recover  input  1  mispredict; restore head from slot recover_id.
REQ-013 SHALL have port recover_id  input  $clog2(NUM_CKPT)  checkpoint slot to restore.
REQ-014 SHALL have port free_count  output  $clog2(NUM_PREGS-NUM_AREGS+1)  registered number of free entries.
REQ-015 SHALL have port empty  output  1  free_count == 0.
REQ-016 SHALL have port dbl_free_err  output  1  sticky double-free flag (present only with macro, see Configuration).

Function
REQ-017 SHALL hold a circular queue of DEPTH = NUM_PREGS-NUM_AREGS entries with head/tail indices wrapping at DEPTH-1 -> 0 plus a wrap bit each.
REQ-018 SHALL drive alloc_valid = !empty && !recover combinationally and alloc_preg = queue[head].
REQ-019 SHALL advance head by one at posedge when alloc_req && alloc_valid; alloc_req with alloc_valid low SHALL change no state.
REQ-020 SHALL write free_preg at queue[tail] and advance tail at posedge when free_valid and free_preg != 0; free_preg == 0 SHALL be ignored.
REQ-021 SHALL ignore a free when free_count == DEPTH (overflow drop).
REQ-022 SHALL update free_count by +1 free, -1 alloc, net 0 for simultaneous alloc and free.
REQ-023 SHALL NOT bypass: a free into an empty queue becomes allocatable the following cycle.
REQ-024 SHALL on ckpt_save store the post-allocation head (head after this cycle's alloc) in slot ckpt_id.
REQ-025 SHALL on recover set head (index and wrap bit) to slot recover_id and recompute free_count = tail - restored head; frees in the same cycle SHALL still enqueue and be counted.
REQ-026 SHALL give recover priority over ckpt_save when both are asserted in one cycle; the save is dropped.

Reset
REQ-027 SHALL on reset == 0 at posedge set queue[i] = NUM_AREGS+i, head = tail = 0 with opposite wrap bits, free_count = DEPTH, empty = 0, all checkpoints = 0, dbl_free_err = 0.
REQ-028 SHALL abandon any in-flight alloc, free or recover on reset, with no partial update.

Configuration
REQ-029 SHALL, with FREE_LIST_DBLFREE_CHECK_EN defined, keep a NUM_PREGS-bit in-queue bitmap; a free of a register already marked free SHALL be dropped and set dbl_free_err until reset; bitmap SHALL be restored consistently on recover.
REQ-030 SHALL, without FREE_LIST_DBLFREE_CHECK_EN, omit the bitmap, drive dbl_free_err constant 0 and enqueue every legal free.

Structure
REQ-031 SHALL take NUM_PREGS, NUM_AREGS, NUM_CKPT, preg_t and ckpt_id_t from the shared package ooo_pkg.
REQ-032 SHALL implement the checkpoint storage as the sub-module free_list_ckpt_table (write port, read port).

Verification
REQ-033 SHALL cover: reset, 96 consecutive allocs -> alloc_preg 32,33,...,127, then empty=1, alloc_valid=0.
REQ-034 SHALL cover: empty, free_preg=40 -> free_count=1 next cycle; alloc -> alloc_preg=40.
REQ-035 SHALL cover: free_count=96, free 50 -> dropped, free_count stays 96.
REQ-036 SHALL cover: ckpt_save slot 1 after 3 allocs, 5 more allocs, recover 1 with concurrent free 33 -> head at preg 35, free_count=94.
REQ-037 SHALL cover: alloc and free same cycle at free_count=10 -> free_count stays 10; free_preg=0 -> no change.
REQ-038 SHALL cover, macro on: free 60 twice without alloc -> second dropped, dbl_free_err=1 until reset.
